// File: rtl/jpeg_stream_packer_pkg.sv
// Shared types and byte constants for the JPEG stream packer.
// code_word_t carries one {code,len,eob} Huffman word at the default widths.
package jpeg_pack_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    EOI_FF = 2'd2,
    EOI_D9 = 2'd3
  } state_e;

  localparam logic [7:0] MARKER_FF = 8'hFF;
  localparam logic [7:0] EOI_LO    = 8'hD9;
  localparam logic [7:0] STUFF     = 8'h00;

  localparam int PKG_CODE_W = 32;
  localparam int PKG_LEN_W  = 6;

  typedef struct packed {
    logic [PKG_CODE_W-1:0] code;
    logic [PKG_LEN_W-1:0]  len;
    logic                  eob;
  } code_word_t;

endpackage

// File: rtl/jpeg_stream_packer_if.sv
// Per-channel code-word inputs, frame control and the packed byte output of the packer.
// slave = packer side, master = producer/sink side.
interface jpeg_stream_packer_if #(
  parameter int NUM_CH = 3,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
);
  logic [NUM_CH-1:0]             in_valid;
  logic [NUM_CH-1:0]             in_ready;
  logic [NUM_CH-1:0][CODE_W-1:0] in_code;
  logic [NUM_CH-1:0][LEN_W-1:0]  in_len;
  logic [NUM_CH-1:0]             in_eob;
  logic                          frame_end;
  logic                          out_valid;
  logic                          out_ready;
  logic [7:0]                    out_data;
  logic                          out_last;
  logic                          busy;

  modport slave (
    input  in_valid, in_code, in_len, in_eob, frame_end, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_code, in_len, in_eob, frame_end, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/jpeg_stream_packer_bit_accumulator.sv
// MSB-first bit accumulator: appends a masked code or 1-padding at the bottom, exposes the oldest byte.
// head is registered-state combinational; pop removes it the same cycle an append may land.
module bit_accumulator import jpeg_pack_pkg::*; #(
  parameter int ACC_W = 64,
  parameter int CODE_W = 32,
  parameter int LEN_W = 6,
  localparam int CNT_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             append,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0] len,
  input  logic             pad,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] bit_cnt
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_bits;
  logic [CNT_W-1:0] add_len;
  logic [2:0]       pad_len;

  always_comb begin
    pad_len  = 3'd0 - bit_cnt[2:0];
    add_len  = '0;
    add_bits = '0;
    if (append) begin
      add_len  = CNT_W'(len);
      add_bits = ACC_W'(code) & ~({ACC_W{1'b1}} << len);
    end else if (pad) begin
      add_len  = CNT_W'(pad_len);
      add_bits = ~({ACC_W{1'b1}} << pad_len);
    end
  end

  // Bits above bit_cnt are stale; only the window below bit_cnt is ever read.
  assign head = 8'(acc >> (bit_cnt - CNT_W'(8)));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else begin
      acc     <= (acc << add_len) | add_bits;
      bit_cnt <= bit_cnt + add_len - (pop ? CNT_W'(8) : CNT_W'(0));
    end
  end
endmodule

// File: rtl/jpeg_stream_packer.sv
// Interleaves per-channel Huffman words in MCU order into a stuffed byte stream ending in FF D9.
// First byte 1 cycle after the accept that fills 8 bits; in_ready drops when a full code may not fit.
module jpeg_stream_packer import jpeg_pack_pkg::*; #(
  parameter int NUM_CH   = 3,
  parameter int Y_BLOCKS = 1,
  parameter int CODE_W   = 32,
  parameter int LEN_W    = 6,
  parameter int ACC_W    = 64
) (
  input logic clk,
  input logic rst,
  jpeg_stream_packer_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(ACC_W + 1);

  state_e           state, state_nxt;
  logic [CH_W-1:0]  grant;
  logic [2:0]       blk_cnt;
  logic             stuff_pend, end_pend, started;
  logic [7:0]       head;
  logic [CNT_W-1:0] bit_cnt;
  logic             room, accept, stall, pad, pop, out_fire, flowing;
  code_word_t       sel;

  always_comb begin
    sel      = '0;
    sel.code = PKG_CODE_W'(bus.in_code[grant]);
    sel.len  = PKG_LEN_W'(bus.in_len[grant]);
    sel.eob  = bus.in_eob[grant];
  end

  assign room     = (int'(bit_cnt) + CODE_W) <= ACC_W;
  assign flowing  = (state == RUN) || (state == FLUSH);
  assign accept   = |(bus.in_valid & bus.in_ready);
  assign stall    = bus.in_valid[grant] && !room;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign pop      = out_fire && flowing && !stuff_pend;
  assign bus.busy = started || (state != RUN) || (bit_cnt != '0);

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++)
      bus.in_ready[i] = !rst && (state == RUN) && room && (grant == CH_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_data  = STUFF;
    bus.out_last  = 1'b0;
    pad           = 1'b0;
    case (state)
      RUN: begin
        bus.out_valid = stuff_pend || (bit_cnt >= CNT_W'(8));
        bus.out_data  = stuff_pend ? STUFF : head;
        // A word still waiting for room belongs to this frame, so hold off the flush.
        if ((bus.frame_end || end_pend) && !stall) state_nxt = FLUSH;
      end
      FLUSH: begin
        bus.out_valid = stuff_pend || (bit_cnt >= CNT_W'(8));
        bus.out_data  = stuff_pend ? STUFF : head;
        pad           = 1'b1;
        if ((bit_cnt == '0) && !stuff_pend) state_nxt = EOI_FF;
      end
      EOI_FF: begin
        bus.out_valid = 1'b1;
        bus.out_data  = MARKER_FF;
        if (bus.out_ready) state_nxt = EOI_D9;
      end
      EOI_D9: begin
        bus.out_valid = 1'b1;
        bus.out_data  = EOI_LO;
        bus.out_last  = 1'b1;
        if (bus.out_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      blk_cnt    <= '0;
      stuff_pend <= 1'b0;
      end_pend   <= 1'b0;
      started    <= 1'b0;
    end else begin
      if (out_fire && flowing) stuff_pend <= !stuff_pend && (head == MARKER_FF);
      end_pend <= (state == RUN) && (bus.frame_end || end_pend) && stall;
      if (accept) started <= 1'b1;
      if (accept && sel.eob) begin
        if (grant == '0) begin
          if (blk_cnt == 3'(Y_BLOCKS - 1)) begin
            blk_cnt <= '0;
            grant   <= (NUM_CH > 1) ? CH_W'(1) : '0;
          end else begin
            blk_cnt <= blk_cnt + 3'd1;
          end
        end else begin
          grant <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end
      end
      if ((state == EOI_D9) && bus.out_ready) begin
        grant   <= '0;
        blk_cnt <= '0;
        started <= 1'b0;
      end
    end
  end

  a_len_legal: assert property (@(posedge clk) disable iff (rst)
    accept |-> (int'(bus.in_len[grant]) <= CODE_W));

  bit_accumulator #(.ACC_W(ACC_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .append (accept),
    .code   (CODE_W'(sel.code)),
    .len    (LEN_W'(sel.len)),
    .pad    (pad),
    .pop    (pop),
    .head   (head),
    .bit_cnt(bit_cnt)
  );
endmodule
